// File: rtl/fpga_config_ctrl_if.sv
// Configuration word stream between a bitstream source and the FPGA config controller.
// The source drives the word and its valid flag; the controller answers with ready.
interface fpga_config_ctrl_if;
    logic        cfg_valid_i;
    logic [17:0] cfg_data_i;
    logic        cfg_ready_o;

    modport master (
        output cfg_valid_i,
        output cfg_data_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_data_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/fpga_config_ctrl.sv
// Loads one LUT truth table plus sync/carry mux selects into each logic cell in turn, then
// verifies an XOR checksum and enables the fabric flip-flops only if the checksum matched.
module fpga_config_ctrl #(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    fpga_config_ctrl_if.slave    cfg,
    output logic [15:0]          config_lut_o,
    output logic [NUM_CELLS-1:0] config_lut_we_o,
    output logic [NUM_CELLS-1:0] mux_sync_o,
    output logic [NUM_CELLS-1:0] mux_carry_o,
    output logic                 fabric_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [15:0]          r_csum;
    logic [15:0]          r_lut;
    logic [1:0]           r_hold_mux;
    logic [NUM_CELLS-1:0] r_we;
    logic [NUM_CELLS-1:0] r_mux_sync;
    logic [NUM_CELLS-1:0] r_mux_carry;
    logic                 r_fabric_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_start_ok;
    logic                 w_csum_ok;
    logic [NUM_CELLS-1:0] w_we_onehot;

    // Ready is a pure state decode, so it never depends combinationally on cfg_valid_i.
    assign w_ready     = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_hs        = cfg.cfg_valid_i && w_ready;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_start_ok  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_csum_ok   = (cfg.cfg_data_i[15:0] == r_csum);
    assign w_we_onehot = NUM_CELLS'(1) << r_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
                if (w_hs) begin
                    w_next = w_csum_ok ? S_DONE : S_ERROR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status flags and the write strobe are registered from the next state so they line up
    // exactly with the state they describe while having no input-to-output path.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fabric_en <= 1'b0;
            r_we        <= '0;
        end else begin
            r_busy      <= (w_next == S_LOAD) || (w_next == S_WRITE) || (w_next == S_CHECK);
            r_done      <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERROR);
            r_fabric_en <= (w_next == S_DONE);
            r_we        <= (w_next == S_WRITE) ? w_we_onehot : '0;
        end
    end

    // The LUT bus register doubles as the holding register, so it keeps the last written table.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lut       <= '0;
            r_hold_mux  <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_mux_sync  <= '0;
            r_mux_carry <= '0;
        end else begin
            if (w_start_ok) begin
                r_idx  <= '0;
                r_csum <= '0;
            end
            if ((r_state == S_LOAD) && w_hs) begin
                r_lut      <= cfg.cfg_data_i[15:0];
                r_hold_mux <= cfg.cfg_data_i[17:16];
            end
            if (r_state == S_WRITE) begin
                r_mux_sync[r_idx]  <= r_hold_mux[1];
                r_mux_carry[r_idx] <= r_hold_mux[0];
                r_csum             <= r_csum ^ r_lut;
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign cfg.cfg_ready_o = w_ready;
    assign config_lut_o    = r_lut;
    assign config_lut_we_o = r_we;
    assign mux_sync_o      = r_mux_sync;
    assign mux_carry_o     = r_mux_carry;
    assign fabric_en_o     = r_fabric_en;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule

// File: doc/fpga_config_ctrl.md
FPGA_CONFIG_CTRL -- requirements
Module: fpga_config_ctrl

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 8, number of logic cells configured (legal range 2..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_CELLS), cell index width.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  one-cycle request to begin a configuration load.
REQ-006 cfg_valid_i  in  1  config word valid.
REQ-007 cfg_data_i  in  18  config word: [17] mux_sync, [16] mux_carry, [15:0] LUT truth table (checksum word uses [15:0] only).
REQ-008 cfg_ready_o  out  1  controller accepts cfg_data_i this cycle.
REQ-009 config_lut_o  out  16  shared LUT config bus to all cells.
REQ-010 config_lut_we_o  out  NUM_CELLS  one-hot per-cell LUT write enable.
REQ-011 mux_sync_o  out  NUM_CELLS  per-cell sync/async select, static after load.
REQ-012 mux_carry_o  out  NUM_CELLS  per-cell carry-in select, static after load.
REQ-013 fabric_en_o  out  1  enables cell flip-flops (dffe) once configuration is valid.
REQ-014 busy_o  out  1  load in progress.
REQ-015 done_o  out  1  load completed and checksum matched.
REQ-016 err_o  out  1  load completed and checksum mismatched.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR: start_i=1 -> LOAD next cycle; cell index and running checksum cleared to 0; done_o, err_o, fabric_en_o drop to 0 that same transition.
REQ-019 start_i SHALL be ignored in LOAD, WRITE, CHECK.
REQ-020 LOAD: cfg_ready_o=1; on cfg_valid_i&cfg_ready_o capture word into holding register, -> WRITE; else stay.
REQ-021 WRITE (exactly one cycle): cfg_ready_o=0; config_lut_o=held[15:0]; config_lut_we_o[idx]=1, all other bits 0; mux_sync_o[idx]<=held[17], mux_carry_o[idx]<=held[16]; checksum <= checksum XOR held[15:0].
REQ-022 WRITE exit: idx==NUM_CELLS-1 -> CHECK; else idx<=idx+1, -> LOAD.
REQ-023 Throughput: one cell per 2 cycles minimum; back-to-back cfg_valid_i SHALL be stalled by cfg_ready_o=0 in WRITE, no word lost or duplicated.
REQ-024 CHECK: cfg_ready_o=1; on handshake compare cfg_data_i[15:0] with running checksum: equal -> DONE, unequal -> ERROR; bits [17:16] ignored.
REQ-025 DONE: done_o=1, fabric_en_o=1, busy_o=0.
REQ-026 ERROR: err_o=1, fabric_en_o=0, busy_o=0.
REQ-027 busy_o=1 exactly in LOAD, WRITE, CHECK.
REQ-028 config_lut_we_o SHALL be all-zero outside WRITE; config_lut_o SHALL hold the last written value otherwise.
REQ-029 mux_sync_o/mux_carry_o bits of cells not yet written in a load SHALL retain prior values; they change only in WRITE for the indexed cell.
REQ-030 fabric_en_o SHALL never be 1 while busy_o=1.
REQ-031 Outputs fabric_en_o, done_o, err_o, busy_o, config_lut_we_o, mux_*_o SHALL be registered (no combinational path from inputs), except cfg_ready_o which is decoded from state only.

Reset
REQ-032 reset_i=1 SHALL immediately (asynchronously) force: state IDLE, idx 0, checksum 0, config_lut_o 0, config_lut_we_o 0, mux_sync_o 0, mux_carry_o 0, fabric_en_o 0, busy_o 0, done_o 0, err_o 0, cfg_ready_o 0.
REQ-033 Reset asserted mid-load SHALL abort the load with no further write-enable pulse; after release controller stays in IDLE until start_i.

Verification
REQ-034 NUM_CELLS=8, start, 8 words LUT=16'h0001<<k, sync=k[0], carry=0, then checksum 16'h00FF -> one we pulse per cell in order 0..7, mux_sync_o=8'hAA, done_o=1, fabric_en_o=1.
REQ-035 Same load with checksum 16'h00FE -> err_o=1, done_o=0, fabric_en_o=0.
REQ-036 cfg_valid_i held high continuously -> cfg_ready_o alternates 1/0, exactly 8 we pulses, CHECK consumes 9th word, load completes in 18 cycles after start.
REQ-037 reset_i pulsed after cell 3 written -> all outputs zero immediately, no we pulse after reset; new start reloads all 8 cells correctly.
REQ-038 start_i during LOAD -> ignored, idx unchanged; start_i in DONE -> done_o and fabric_en_o drop next cycle, new load begins.
REQ-039 cfg_valid_i gapped randomly (0-5 idle cycles) -> identical cell contents and done_o as gap-free run.
